// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_pkg
//  Purpose  : Shared definitions for the pipelined adder/subtractor:
//             default geometry, per-stage control payload and saturation
//             limit helpers.
//  Revision : 1.0  initial release
// ============================================================================
package addsub_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;
  // Widest operand the saturation helpers can describe.
  localparam int MAX_WIDTH  = 256;

  // Control half of each stage register; the operand and partial-sum words
  // sit beside it as WIDTH-bit arrays because their width is a module
  // parameter.
  typedef struct packed {
    logic valid;  // beat present in this stage
    logic carry;  // carry out of the slice this stage completed
  } stage_ctrl_t;

  // Largest positive value of a w-bit two's-complement number (0111..1).
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Most negative value of a w-bit two's-complement number (1000..0).
  function automatic logic [MAX_WIDTH-1:0] sat_min(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_slice
//  Purpose  : W-bit combinational ripple-carry adder slice (a + b + ci).
//  Revision : 1.0  initial release
// ============================================================================
module addsub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[W];

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_addsub
//  Purpose  : Pipelined two's-complement adder/subtractor. The WIDTH-bit
//             carry chain is cut into STAGES slices with a register after
//             each; valid/ready handshake on both sides, whole-pipe stall.
//  Options  : define ADDSUB_SAT_EN to clamp the result to the signed limits
//             on overflow (cout and ovf unaffected).
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipelined_addsub: STAGES must lie in 1..WIDTH");
  end
  if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  // Subtraction is a + ~b + ~cin, so a borrow-in becomes a missing carry-in.
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;

  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage registers: operands travel whole so later slices find their bits,
  // the partial sum fills in one slice per stage.
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] s_q    [STAGES];
  stage_ctrl_t      ctrl_q [STAGES];

  // What each stage sees on its input side.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic [SLICE-1:0] sl_s  [STAGES];
  logic             sl_co [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_in[k] = a;
      assign b_in[k] = b_eff;
      assign s_in[k] = '0;
      assign c_in[k] = c0;
      assign v_in[k] = in_valid;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = ctrl_q[k-1].carry;
      assign v_in[k] = ctrl_q[k-1].valid;
    end

    addsub_slice #(
      .W (SLICE)
    ) u_slice (
      .a  (a_in[k][k*SLICE +: SLICE]),
      .b  (b_in[k][k*SLICE +: SLICE]),
      .ci (c_in[k]),
      .s  (sl_s[k]),
      .co (sl_co[k])
    );
  end

  // Advance every stage together when the output can move; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        s_q[k]    <= '0;
        ctrl_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]                     <= a_in[k];
        b_q[k]                     <= b_in[k];
        s_q[k]                     <= s_in[k];
        s_q[k][k*SLICE +: SLICE]   <= sl_s[k];
        ctrl_q[k].valid            <= v_in[k];
        ctrl_q[k].carry            <= sl_co[k];
      end
    end
  end

  logic [WIDTH-1:0] raw_sum;
  logic             a_msb;
  logic             b_msb;

  assign raw_sum   = s_q[LAST];
  assign a_msb     = a_q[LAST][MSB];
  assign b_msb     = b_q[LAST][MSB];
  assign out_valid = ctrl_q[LAST].valid;
  assign cout      = ctrl_q[LAST].carry;
  // Like-signed operands producing an opposite-signed result.
  assign ovf       = (a_msb == b_msb) && (raw_sum[MSB] != a_msb);

`ifdef ADDSUB_SAT_EN
  localparam logic [MAX_WIDTH-1:0] SAT_HI_FULL = sat_max(WIDTH);
  localparam logic [MAX_WIDTH-1:0] SAT_LO_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0]     SAT_HI      = SAT_HI_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_LO      = SAT_LO_FULL[WIDTH-1:0];

  // Overflow direction follows the operand sign: negative operands can
  // only overflow downward.
  assign sum = ovf ? (a_msb ? SAT_LO : SAT_HI) : raw_sum;
`else
  assign sum = raw_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_addsub
//  Purpose  : Self-checking bench; three instances (STAGES 4, 1, 16) share
//             the input stream, each with its own in-order scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_addsub;

  localparam int W  = 16;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_ready;

  logic          in_ready_v  [NI];
  logic          out_valid_v [NI];
  logic [W-1:0]  sum_v       [NI];
  logic          cout_v      [NI];
  logic          ovf_v       [NI];
  int            outstanding [NI];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  function automatic int st_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 16);
  endfunction

  // Expected {sum, cout, ovf} from integer arithmetic on the true result.
  function automatic logic [W+1:0] model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                         input logic vc, input logic vs);
    longint ua, ub, sa, sb, ru, rs;
    logic [63:0] ru_bits;
    logic [W-1:0] s;
    logic c, o;
    ua = longint'(va);
    ub = longint'(vb);
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    if (!vs) begin
      ru = ua + ub + longint'(vc);
      rs = sa + sb + longint'(vc);
      c  = (ru >= 65536);
    end else begin
      ru = ua - ub - longint'(vc);
      rs = sa - sb - longint'(vc);
      c  = (ua >= ub + longint'(vc));
    end
    o = (rs > 32767) || (rs < -32768);
    ru_bits = ru;
    s = ru_bits[W-1:0];
`ifdef ADDSUB_SAT_EN
    if (rs > 32767)       s = 16'h7FFF;
    else if (rs < -32768) s = 16'h8000;
`endif
    return {s, c, o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int ST = (i == 0) ? 4 : ((i == 1) ? 1 : 16);
    logic [W+1:0] q [$];

    pipelined_addsub #(
      .WIDTH  (W),
      .STAGES (ST)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[i]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid_v[i]),
      .out_ready (out_ready),
      .sum       (sum_v[i]),
      .cout      (cout_v[i]),
      .ovf       (ovf_v[i])
    );

    // Mid-cycle: retire the beat leaving at the next edge, then log the one entering.
    always @(negedge clk) begin
      if (rst_n) begin
        if (out_valid_v[i] && out_ready) begin
          check($sformatf("st%0d_beat_present", ST), 32'(q.size() != 0), 32'd1);
          if (q.size() != 0)
            check($sformatf("st%0d_result", ST), 32'({sum_v[i], cout_v[i], ovf_v[i]}), 32'(q.pop_front()));
        end
        if (in_valid && in_ready_v[i]) q.push_back(model(a, b, cin, sub));
        outstanding[i] = q.size();
      end
    end

    // Reset throws away everything in flight.
    always @(negedge rst_n) begin
      q.delete();
      outstanding[i] = 0;
    end
  end

  // Single beat into an empty pipe; checks model, latency and result per instance.
  task automatic run_vec(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic vs, input logic [W+1:0] lit);
    bit seen [NI];
    bit all_seen;
    check({nm, "_model"}, 32'(model(va, vb, vc, vs)), 32'(lit));
    for (int i = 0; i < NI; i++) seen[i] = 1'b0;
    @(posedge clk); #1;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      all_seen = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (!seen[i] && out_valid_v[i]) begin
          seen[i] = 1'b1;
          check($sformatf("%s_latency_st%0d", nm, st_of(i)), 32'(cyc), 32'(st_of(i)));
          check($sformatf("%s_out_st%0d", nm, st_of(i)), 32'({sum_v[i], cout_v[i], ovf_v[i]}), 32'(lit));
        end
        all_seen &= seen[i];
      end
      if (all_seen) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++)
      if (!seen[i]) check($sformatf("%s_timeout_st%0d", nm, st_of(i)), 32'(seen[i]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #12;
    for (int i = 0; i < NI; i++)
      check($sformatf("reset_state_st%0d", st_of(i)),
            32'({out_valid_v[i], sum_v[i], cout_v[i], ovf_v[i], in_ready_v[i]}), 32'h1);
    #5 rst_n = 1'b1;

    run_vec("carry_byte",  16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0});
    run_vec("carry_all",   16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
`ifdef ADDSUB_SAT_EN
    run_vec("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h7FFF, 1'b0, 1'b1});
    run_vec("neg_ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, {16'h8000, 1'b1, 1'b1});
`else
    run_vec("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    run_vec("neg_ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
`endif
    run_vec("sub_neg",     16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    run_vec("sub_borrow",  16'h0000, 16'h0000, 1'b1, 1'b1, {16'hFFFF, 1'b0, 1'b0});
    run_vec("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 1'b0, 1'b0});

    // Random traffic with stalls and a few bubbles.
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      in_valid  = ($urandom_range(0, 7) != 0);
      out_ready = 1'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("drained_st%0d", st_of(i)), 32'(outstanding[i]), 32'd0);

    // Reset with beats in flight and the output stalled.
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      a = W'(16'h0101 * (n + 1)); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_out_st1", 32'(out_valid_v[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("async_reset_st%0d", st_of(i)), 32'({out_valid_v[i], sum_v[i]}), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("ready_after_reset_st%0d", st_of(i)), 32'(in_ready_v[i]), 32'd1);
    out_ready = 1'b1;
    stale = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) if (out_valid_v[i]) stale++;
    end
    check("no_stale_beats", 32'(stale), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
